// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared pipeline definitions: instruction encodings and the IF/ID stall-control state set.
package pipeline_stall_ctrl_pkg;

  localparam logic [3:0]  OPCODE_NOP       = 4'b1111;
  localparam logic [15:0] NOP_WORD_DEFAULT = {OPCODE_NOP, 12'h000};
  localparam logic [7:0]  STALL_COUNT_MAX  = 8'hFF;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } stall_state_e;

endpackage

// File: rtl/pipeline_stall_ctrl_stall_watchdog.sv
// Tracks consecutive and total stall cycles; raises a sticky error when a stall run
// reaches MAX_STALL cycles.
module stall_watchdog
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int MAX_STALL = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         stall,
  input  stall_state_e state,
  output logic [7:0]   stall_count,
  output logic         stall_error
);

  localparam int RUN_W = $clog2(MAX_STALL) + 1;
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL);

  logic [RUN_W-1:0] run_cnt_reg, run_cnt_next;
  logic [7:0]       stall_count_reg, stall_count_next;
  logic             stall_error_reg, stall_error_next;

  always_comb begin
    run_cnt_next     = run_cnt_reg;
    stall_count_next = stall_count_reg;
    stall_error_next = stall_error_reg;
    if (stall) begin
      // Run counter parks at the limit so a long stall cannot wrap it back to zero.
      if (run_cnt_reg != RUN_LIMIT)
        run_cnt_next = run_cnt_reg + 1'b1;
      if (stall_count_reg != STALL_COUNT_MAX)
        stall_count_next = stall_count_reg + 8'd1;
      if (run_cnt_next == RUN_LIMIT)
        stall_error_next = 1'b1;
    end else if (state == STALL) begin
      run_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt_reg     <= '0;
      stall_count_reg <= '0;
      stall_error_reg <= 1'b0;
    end else begin
      run_cnt_reg     <= run_cnt_next;
      stall_count_reg <= stall_count_next;
      stall_error_reg <= stall_error_next;
    end
  end

  assign stall_count = stall_count_reg;
  assign stall_error = stall_error_reg;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// IF/ID pipeline register with flush/stall/bubble control and a stall watchdog.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int          MAX_STALL = 4,
  parameter logic [15:0] NOP_WORD  = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] PC_IF,
  input  logic [15:0] Instruction_IF,
  input  logic        PC_IF_ID_Write_HZ,
  input  logic        B,
  input  logic        Flush,
  output logic        PC_Write,
  output logic        Bubble_ID_EX,
  output logic [15:0] Instruction_PR1,
  output logic [15:0] PC_PR1,
  output logic        Valid_PR1,
  output logic [7:0]  Stall_Count,
  output logic        Stall_Error
);

  stall_state_e state_reg, state_next;
  logic [15:0]  instr_reg, instr_next;
  logic [15:0]  pc_reg, pc_next;
  logic         valid_reg, valid_next;
  logic         stall;

  // A flush overrides a concurrent hold request, so it never counts as a stall.
  assign stall        = !Flush && !PC_IF_ID_Write_HZ;
  assign PC_Write     = Flush | PC_IF_ID_Write_HZ;
  assign Bubble_ID_EX = Flush | B;

  always_comb begin
    state_next = state_reg;
    instr_next = instr_reg;
    pc_next    = pc_reg;
    valid_next = valid_reg;
    case (state_reg)
      RUN:     if (stall) state_next = STALL;
      STALL:   if (PC_IF_ID_Write_HZ || Flush) state_next = RUN;
      default: state_next = RUN;
    endcase
    if (Flush) begin
      instr_next = NOP_WORD;
      pc_next    = PC_IF;
      valid_next = 1'b0;
    end else if (PC_IF_ID_Write_HZ) begin
      instr_next = Instruction_IF;
      pc_next    = PC_IF;
      valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= RUN;
      instr_reg <= NOP_WORD;
      pc_reg    <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      instr_reg <= instr_next;
      pc_reg    <= pc_next;
      valid_reg <= valid_next;
    end
  end

  assign Instruction_PR1 = instr_reg;
  assign PC_PR1          = pc_reg;
  assign Valid_PR1       = valid_reg;

  stall_watchdog #(
    .MAX_STALL(MAX_STALL)
  ) u_stall_watchdog (
    .clk         (clk),
    .reset_n     (reset_n),
    .stall       (stall),
    .state       (state_reg),
    .stall_count (Stall_Count),
    .stall_error (Stall_Error)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench: a driver feeds directed and random cycles and queues expected results;
// a monitor pops and compares one expectation after each rising edge.
module tb_pipeline_stall_ctrl;

  localparam int          MAX_STALL = 4;
  localparam logic [15:0] NOP       = 16'hF000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] PC_IF, Instruction_IF;
  logic        PC_IF_ID_Write_HZ, B, Flush;
  logic        PC_Write, Bubble_ID_EX, Valid_PR1, Stall_Error;
  logic [15:0] Instruction_PR1, PC_PR1;
  logic [7:0]  Stall_Count;

  pipeline_stall_ctrl #(.MAX_STALL(MAX_STALL), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset_n(reset_n), .PC_IF(PC_IF), .Instruction_IF(Instruction_IF),
    .PC_IF_ID_Write_HZ(PC_IF_ID_Write_HZ), .B(B), .Flush(Flush),
    .PC_Write(PC_Write), .Bubble_ID_EX(Bubble_ID_EX), .Instruction_PR1(Instruction_PR1),
    .PC_PR1(PC_PR1), .Valid_PR1(Valid_PR1), .Stall_Count(Stall_Count), .Stall_Error(Stall_Error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pc_write;
    logic        bubble;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        valid;
    logic [7:0]  cnt;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;
  int   txn    = 0;

  // Reference model: architectural view of IF/ID plus stall statistics.
  logic [15:0] m_instr, m_pc;
  logic        m_valid, m_err;
  int          m_run, m_cnt;

  function automatic void m_reset();
    m_instr = NOP; m_pc = 16'h0; m_valid = 1'b0;
    m_run = 0; m_cnt = 0; m_err = 1'b0;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s txn=%0d actual=%h required=%h", name, txn, act, req);
  endtask

  // Drive one cycle at the current negedge, queue its expected outcome, then wait a cycle.
  task automatic cycle(input logic wr, input logic b, input logic fl,
                       input logic [15:0] ins, input logic [15:0] pc);
    exp_t e;
    PC_IF_ID_Write_HZ = wr; B = b; Flush = fl; Instruction_IF = ins; PC_IF = pc;
    e.pc_write = fl | wr;
    e.bubble   = fl | b;
    if (fl) begin
      m_instr = NOP; m_pc = pc; m_valid = 1'b0; m_run = 0;
    end else if (!wr) begin
      m_run++;
      if (m_cnt < 255) m_cnt++;
      if (m_run >= MAX_STALL) m_err = 1'b1;
    end else begin
      m_instr = ins; m_pc = pc; m_valid = 1'b1; m_run = 0;
    end
    e.instr = m_instr; e.pc = m_pc; e.valid = m_valid;
    e.cnt = 8'(m_cnt); e.err = m_err;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Pull reset low between edges and confirm outputs clear without a clock edge.
  task automatic async_reset_check();
    #2 reset_n = 1'b0;
    #1;
    m_reset();
    txn++;
    chk("rst_instr", Instruction_PR1, m_instr);
    chk("rst_pc",    PC_PR1,          m_pc);
    chk("rst_valid", 16'(Valid_PR1),  16'(m_valid));
    chk("rst_cnt",   16'(Stall_Count), 16'(m_cnt));
    chk("rst_err",   16'(Stall_Error), 16'(m_err));
    $display("txn %0d: async reset instr=%h pc=%h valid=%b cnt=%0d err=%b",
             txn, Instruction_PR1, PC_PR1, Valid_PR1, Stall_Count, Stall_Error);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        chk("pc_write",  16'(PC_Write),     16'(e.pc_write));
        chk("bubble",    16'(Bubble_ID_EX), 16'(e.bubble));
        chk("instr_pr1", Instruction_PR1,   e.instr);
        chk("pc_pr1",    PC_PR1,            e.pc);
        chk("valid_pr1", 16'(Valid_PR1),    16'(e.valid));
        chk("stall_cnt", 16'(Stall_Count),  16'(e.cnt));
        chk("stall_err", 16'(Stall_Error),  16'(e.err));
        $display("txn %0d: wr=%b b=%b fl=%b -> instr=%h pc=%h valid=%b cnt=%0d err=%b",
                 txn, PC_IF_ID_Write_HZ, B, Flush, Instruction_PR1, PC_PR1,
                 Valid_PR1, Stall_Count, Stall_Error);
      end
    end
  end

  initial begin : driver
    int wait_cycles;
    reset_n = 1'b0;
    PC_IF = 16'h0; Instruction_IF = 16'h0;
    PC_IF_ID_Write_HZ = 1'b1; B = 1'b0; Flush = 1'b0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    txn++;
    chk("por_instr", Instruction_PR1, NOP);
    chk("por_pc",    PC_PR1,          16'h0);
    chk("por_valid", 16'(Valid_PR1),  16'h0);
    chk("por_cnt",   16'(Stall_Count), 16'h0);
    chk("por_err",   16'(Stall_Error), 16'h0);
    reset_n = 1'b1;

    cycle(1, 0, 0, 16'h1234, 16'h0010);   // normal advance
    cycle(0, 1, 0, 16'hAAAA, 16'h0012);   // one stall with bubble
    cycle(0, 1, 1, 16'hBBBB, 16'h0014);   // flush beats stall
    cycle(1, 1, 0, 16'h2222, 16'h0016);   // bubble while advancing
    for (int i = 0; i < MAX_STALL - 1; i++) cycle(0, 0, 0, 16'h3333, 16'h0018);
    cycle(1, 0, 0, 16'h4444, 16'h001A);   // release before watchdog limit
    for (int i = 0; i < MAX_STALL; i++) cycle(0, 0, 0, 16'h5555, 16'h001C);
    cycle(1, 0, 0, 16'h6666, 16'h001E);
    cycle(1, 0, 0, 16'h7777, 16'h0020);

    cycle(0, 0, 0, 16'h8888, 16'h0022);
    cycle(0, 0, 0, 16'h8888, 16'h0022);
    async_reset_check();                   // reset abandons a stall
    cycle(1, 0, 0, 16'h9999, 16'h0030);

    for (int i = 0; i < 250; i++) begin
      cycle(($urandom_range(0, 9) > 2) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 6) == 0),
            16'($urandom), 16'($urandom));
    end

    for (int i = 0; i < 300; i++) cycle(0, 1'($urandom), 0, 16'($urandom), 16'h0100);
    cycle(1, 0, 0, 16'hCAFE, 16'h0200);
    cycle(0, 0, 0, 16'hBEEF, 16'h0202);
    async_reset_check();
    cycle(1, 0, 0, 16'h0F0F, 16'h0300);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(negedge clk);
      wait_cycles++;
    end
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain pending=%0d required=0", exp_q.size());
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
